// File: rtl/and_net_settle_monitor_pkg.sv
// Shared definitions for the AND-network settle monitor: FSM state
// encoding, synchroniser depth, comparison start cycle and glitch width.
`timescale 1ns/1ps
package and_net_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Number of flops between the asynchronous net output and the FSM.
  localparam int SYNC_STAGES = 2;

  // First cnt value at which the synchronised output reflects post-launch
  // data (launch edge + SYNC_STAGES sampling edges).
  localparam int CMP_START = 3;

  // Width of the saturating glitch counter.
  localparam int GLITCH_W = 4;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/and_net_settle_monitor_sync2.sv
// Multi-flop synchroniser for a single asynchronous bit; all flops clear
// to 0 on reset so the first synchronised value after reset is known.
`timescale 1ns/1ps
module sync2
  import and_net_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/and_net_settle_monitor.sv
// Launch-and-measure wrapper for the four-input AND delay network.
// Drives a registered test vector onto the network, synchronises the
// network output, and reports settle time, glitch count and timeout.
//
// Launch handshake: a launch is accepted on any rising clock edge where
// launch_valid && launch_ready. launch_ready is high only in IDLE, so while
// a measurement is in flight launch_valid is ignored and launch_vec may
// change freely without affecting drv_vec.
`timescale 1ns/1ps
module and_net_settle_monitor
  import and_net_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STABLE_CNT = 2,
  parameter int TIMEOUT    = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                launch_valid,
  output logic                launch_ready,
  input  logic [3:0]          launch_vec,
  output logic [3:0]          drv_vec,
  input  logic                net_out,
  output logic                expected,
  output logic                done,
  output logic [CNT_W-1:0]    settle_cycles,
  output logic                timeout,
  output logic [GLITCH_W-1:0] glitches,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_STABLE = STABLE;
  localparam logic [1:0] ST_REPORT = REPORT;

  localparam logic [CNT_W-1:0] CMP_START_C = CNT_W'(CMP_START);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_C    = CNT_W'(STABLE_CNT);

  logic [1:0]       state;
  logic             s;
  logic             s_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stab;
  logic [CNT_W-1:0] first;

  logic             cmp_en;
  logic             match;
  logic             toggled;
  logic [CNT_W-1:0] stab_nxt;

  sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (net_out),
    .q       (s)
  );

  // Delayed copy of the synchronised output for transition detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  // Blanking: before CMP_START the synchroniser still holds pre-launch data.
  assign cmp_en   = (cnt >= CMP_START_C);
  assign match    = (s == expected);
  assign toggled  = (s != s_prev);
  // A match in WAIT starts a new run of one; in STABLE it extends the run.
  assign stab_nxt = (state == ST_WAIT) ? CNT_W'(1) : stab + CNT_W'(1);

  assign launch_ready = (state == ST_IDLE);
  assign dbg_state    = state;

  // Measurement FSM: launch, blank, watch for a stable match, report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      drv_vec       <= '0;
      expected      <= 1'b0;
      done          <= 1'b0;
      settle_cycles <= '0;
      timeout       <= 1'b0;
      glitches      <= '0;
      cnt           <= '0;
      stab          <= '0;
      first         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_valid) begin
            drv_vec  <= launch_vec;
            expected <= &launch_vec;
            cnt      <= CNT_W'(1);
            stab     <= '0;
            glitches <= '0;
            timeout  <= 1'b0;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT, ST_STABLE: begin
          if (cmp_en && toggled) begin
            glitches <= sat_inc(glitches);
          end
          // Timeout wins over a settle completing on the same edge.
          if (cnt == TIMEOUT_C) begin
            settle_cycles <= TIMEOUT_C;
            timeout       <= 1'b1;
            done          <= 1'b1;
            state         <= ST_REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cmp_en) begin
              if (match) begin
                stab <= stab_nxt;
                if (state == ST_WAIT) begin
                  first <= cnt;
                end
                if (stab_nxt == STABLE_C) begin
                  settle_cycles <= (state == ST_WAIT) ? cnt : first;
                  done          <= 1'b1;
                  state         <= ST_REPORT;
                end else begin
                  state <= ST_STABLE;
                end
              end else begin
                stab  <= '0;
                state <= ST_WAIT;
              end
            end
          end
        end

        ST_REPORT: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_net_settle_monitor.sv
// Directed bench for and_net_settle_monitor: a behavioural model of the
// AND delay network (rise 11 ns, fall 9 ns) or a bench-forced net_out,
// a 4 ns clock, and one task per scenario with hand-computed results.
`timescale 1ns/1ps
module tb_and_net_settle_monitor;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       launch_valid;
  logic [3:0] launch_vec;
  logic       launch_ready;
  logic [3:0] drv_vec;
  logic       net_out;
  logic       expected;
  logic       done;
  logic [7:0] settle_cycles;
  logic       timeout;
  logic [3:0] glitches;
  logic [1:0] dbg_state;

  logic net_model = 1'b0;
  logic net_force = 1'b0;
  logic use_model = 1'b1;
  int   net_delay;

  int n_checks = 0;
  int n_fail   = 0;

  and_net_settle_monitor dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .launch_valid  (launch_valid),
    .launch_ready  (launch_ready),
    .launch_vec    (launch_vec),
    .drv_vec       (drv_vec),
    .net_out       (net_out),
    .expected      (expected),
    .done          (done),
    .settle_cycles (settle_cycles),
    .timeout       (timeout),
    .glitches      (glitches),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #2 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- network model ----------------
  always @(drv_vec) begin
    net_delay = (&drv_vec) ? 11 : 9;
    net_model <= #(net_delay) (&drv_vec);
  end

  assign net_out = use_model ? net_model : net_force;

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [3:0] vec);
    @(negedge clock);
    launch_vec   = vec;
    launch_valid = 1'b1;
    @(posedge clock);
    #1;
    launch_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k, output bit seen);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < budget) begin
      @(negedge clock);
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n      = 1'b0;
    launch_valid = 1'b0;
    launch_vec   = 4'b0000;
    #3;
    n_checks++;
    if ({drv_vec, expected, done, settle_cycles, timeout, glitches} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got drv=%b exp=%b done=%b settle=%0d to=%b gl=%0d, want all 0",
               drv_vec, expected, done, settle_cycles, timeout, glitches);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (launch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", launch_ready);
    end
  endtask

  task automatic test_rise();
    int k; bit seen;
    launch(4'b1111);
    n_checks++;
    if (expected !== 1'b1 || dbg_state !== 2'd1 || launch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_launch: got exp=%b state=%0d ready=%b want 1/1/0", expected, dbg_state, launch_ready);
    end
    wait_done(30, k, seen);
    n_checks++;
    if (!seen || k != 7) begin
      n_fail++;
      $display("FAIL rise_done_edge: got seen=%0d k=%0d want k=7", seen, k);
    end
    n_checks++;
    if (settle_cycles !== 8'd5 || glitches !== 4'd1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_result: got settle=%0d gl=%0d to=%b want 5/1/0", settle_cycles, glitches, timeout);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || launch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_done_pulse: got done=%b ready=%b want 0/1", done, launch_ready);
    end
  endtask

  task automatic test_fall();
    int k; bit seen;
    launch(4'b0111);
    n_checks++;
    if (expected !== 1'b0 || drv_vec !== 4'b0111) begin
      n_fail++;
      $display("FAIL fall_launch: got exp=%b drv=%b want 0/0111", expected, drv_vec);
    end
    wait_done(30, k, seen);
    n_checks++;
    if (!seen || k != 7) begin
      n_fail++;
      $display("FAIL fall_done_edge: got seen=%0d k=%0d want k=7", seen, k);
    end
    n_checks++;
    if (settle_cycles !== 8'd5 || glitches !== 4'd1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_result: got settle=%0d gl=%0d to=%b want 5/1/0", settle_cycles, glitches, timeout);
    end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int k; bit seen;
    net_force = 1'b0;
    use_model = 1'b0;
    launch(4'b1111);
    wait_done(250, k, seen);
    n_checks++;
    if (!seen || k != 201) begin
      n_fail++;
      $display("FAIL timeout_done_edge: got seen=%0d k=%0d want k=201", seen, k);
    end
    n_checks++;
    if (settle_cycles !== 8'd200 || timeout !== 1'b1 || glitches !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_result: got settle=%0d to=%b gl=%0d want 200/1/0", settle_cycles, timeout, glitches);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || timeout !== 1'b1 || settle_cycles !== 8'd200) begin
      n_fail++;
      $display("FAIL timeout_hold: got done=%b to=%b settle=%0d want 0/1/200", done, timeout, settle_cycles);
    end
  endtask

  task automatic test_glitch();
    int k; bit seen;
    net_force = 1'b0;
    use_model = 1'b0;
    launch(4'b1111);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (k == 3) net_force = 1'b1;
        if (k == 4) net_force = 1'b0;
        if (k == 7) net_force = 1'b1;
      end
    end
    n_checks++;
    if (!seen || k != 11) begin
      n_fail++;
      $display("FAIL glitch_done_edge: got seen=%0d k=%0d want k=11", seen, k);
    end
    n_checks++;
    if (glitches !== 4'd3 || settle_cycles !== 8'd9 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_result: got gl=%0d settle=%0d to=%b want 3/9/0", glitches, settle_cycles, timeout);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int k; bit seen;
    bit done_seen;
    use_model = 1'b1;
    launch(4'b0111);
    repeat (3) @(negedge clock);
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL rmid_in_wait: got state=%0d want 1", dbg_state);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({drv_vec, expected, done, settle_cycles, timeout, glitches} !== 19'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got drv=%b exp=%b done=%b settle=%0d to=%b gl=%0d, want all 0",
               drv_vec, expected, done, settle_cycles, timeout, glitches);
    end
    done_seen = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen || launch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_after_release: got done_seen=%0d ready=%b want 0/1", done_seen, launch_ready);
    end
    launch(4'b1111);
    wait_done(30, k, seen);
    n_checks++;
    if (!seen || k != 7 || settle_cycles !== 8'd5 || glitches !== 4'd1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_fresh: got k=%0d settle=%0d gl=%0d to=%b want 7/5/1/0", k, settle_cycles, glitches, timeout);
    end
    @(negedge clock);
  endtask

  task automatic test_hold();
    int k; bit seen;
    int bad_drv, bad_ready;
    bad_drv   = 0;
    bad_ready = 0;
    @(negedge clock);
    launch_vec   = 4'b1110;
    launch_valid = 1'b1;
    @(posedge clock);
    #1;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (drv_vec !== 4'b1110) bad_drv++;
      if (launch_ready !== 1'b0) bad_ready++;
      if (done === 1'b1) begin
        seen = 1'b1;
        launch_valid = 1'b0;
      end else begin
        launch_vec = k[0] ? 4'b1111 : 4'b0000;
      end
    end
    launch_valid = 1'b0;
    n_checks++;
    if (bad_drv != 0 || bad_ready != 0) begin
      n_fail++;
      $display("FAIL hold_ignore: got bad_drv=%0d bad_ready=%0d cycles want 0/0", bad_drv, bad_ready);
    end
    n_checks++;
    if (!seen || k != 7 || expected !== 1'b0 || settle_cycles !== 8'd5 || glitches !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_result: got k=%0d exp=%b settle=%0d gl=%0d want 7/0/5/1", k, expected, settle_cycles, glitches);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || launch_ready !== 1'b1 || drv_vec !== 4'b1110) begin
      n_fail++;
      $display("FAIL hold_after: got done=%b ready=%b drv=%b want 0/1/1110", done, launch_ready, drv_vec);
    end
  endtask

  task automatic test_min_settle();
    int k; bit seen;
    launch(4'b1110);
    wait_done(30, k, seen);
    n_checks++;
    if (!seen || k != 5) begin
      n_fail++;
      $display("FAIL min_done_edge: got seen=%0d k=%0d want k=5", seen, k);
    end
    n_checks++;
    if (settle_cycles !== 8'd3 || glitches !== 4'd0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL min_result: got settle=%0d gl=%0d to=%b want 3/0/0", settle_cycles, glitches, timeout);
    end
    @(negedge clock);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_hold();
    test_min_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
